lifo_stack_sync: RTL and testbench

//  Parametrised synchronous LIFO stack for the CPU datapath (call/return, operand spill).

---
 rtl/lifo_stack_sync.sv | 138 +++++++++++++
 tb/tb_lifo_stack_sync.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_sync.sv
// ============================================================================
// Module  : lifo_stack_sync
// Brief   : Synchronous LIFO stack with push/pop/replace, registered pop data,
//           occupancy count and sticky overflow/underflow flags.
//           Optional AlmostFull output enabled by defining LIFO_ALMOST_FULL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_stack_sync #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 8
`ifdef LIFO_ALMOST_FULL_EN
    ,
    parameter int AF_LVL = 6
`endif
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Push,
    input  logic                         Pop,
    input  logic                         ErrClr,
    input  logic [WIDTH-1:0]             DataIn,
    output logic [WIDTH-1:0]             DataOut,
    output logic                         DataValid,
    output logic [WIDTH-1:0]             Top,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic                         Underflow
`ifdef LIFO_ALMOST_FULL_EN
    ,
    output logic                         AlmostFull
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dv;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_repl;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_pop_only;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_wr_en;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_top_raw;
    logic [CW-1:0]    w_count_nxt;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_top_idx  = AW'(r_count - CW'(1));
    assign w_top_raw  = r_mem[w_top_idx];

    // Replace on an empty stack degenerates to a plain push plus an underflow.
    assign w_repl     = Push & Pop & ~w_empty;
    assign w_push_ok  = (Push & ~Pop & ~w_full) | (Push & Pop & w_empty);
    assign w_pop_ok   = Pop & ~w_empty;
    assign w_pop_only = Pop & ~Push & ~w_empty;
    assign w_ovf_evt  = Push & ~Pop & w_full;
    assign w_unf_evt  = Pop & w_empty;

    assign w_wr_en    = w_push_ok | w_repl;
    assign w_wr_idx   = w_repl ? w_top_idx : AW'(r_count);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_only) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dv    <= w_pop_ok;
            if (w_pop_ok) begin
                r_dout <= w_top_raw;
            end
            // A fresh error in the clear cycle keeps the flag set.
            r_ovf <= w_ovf_evt | (r_ovf & ~ErrClr);
            r_unf <= w_unf_evt | (r_unf & ~ErrClr);
        end
    end

    // Storage carries no reset; only the count defines valid contents.
    always_ff @(posedge Clk) begin
        if (!Reset && w_wr_en) begin
            r_mem[w_wr_idx] <= DataIn;
        end
    end

`ifdef LIFO_ALMOST_FULL_EN
    logic r_af;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_af <= 1'b0;
        end else begin
            r_af <= (w_count_nxt >= CW'(AF_LVL));
        end
    end

    assign AlmostFull = r_af;
`endif

    assign DataOut   = r_dout;
    assign DataValid = r_dv;
    assign Top       = w_empty ? '0 : w_top_raw;
    assign Count     = r_count;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_lifo_stack_sync.sv
// ============================================================================
// Module  : tb_lifo_stack_sync
// Brief   : Directed self-checking bench for lifo_stack_sync with a stack model
//           and a queue of expected pop data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lifo_stack_sync;

    localparam int WIDTH  = 12;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int CW     = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Push;
    logic             Pop;
    logic             ErrClr;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] DataOut;
    logic             DataValid;
    logic [WIDTH-1:0] Top;
    logic [CW-1:0]    Count;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic             Underflow;
`ifdef LIFO_ALMOST_FULL_EN
    logic             AlmostFull;
`endif

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_unf;
    logic [WIDTH-1:0] m_dout;

    lifo_stack_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
`ifdef LIFO_ALMOST_FULL_EN
        ,
        .AF_LVL(AF_LVL)
`endif
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Push      (Push),
        .Pop       (Pop),
        .ErrClr    (ErrClr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .Top       (Top),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
`ifdef LIFO_ALMOST_FULL_EN
        ,
        .AlmostFull(AlmostFull)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [WIDTH-1:0] exp_top;
        exp_top = (stk.size() == 0) ? '0 : stk[stk.size()-1];
        chk("count",     32'(Count),     32'(stk.size()));
        chk("empty",     32'(Empty),     32'(stk.size() == 0));
        chk("full",      32'(Full),      32'(stk.size() == DEPTH));
        chk("top",       32'(Top),       32'(exp_top));
        chk("overflow",  32'(Overflow),  32'(m_ovf));
        chk("underflow", 32'(Underflow), 32'(m_unf));
`ifdef LIFO_ALMOST_FULL_EN
        chk("almostfull", 32'(AlmostFull), 32'(stk.size() >= AF_LVL));
`endif
    endtask

    // One clock of stimulus; the model predicts the post-edge state.
    task automatic step(input bit pu, input bit po, input bit clr, input logic [WIDTH-1:0] d);
        bit valid;
        bit ovf_evt;
        bit unf_evt;
        valid   = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        Push   = pu;
        Pop    = po;
        ErrClr = clr;
        DataIn = d;
        if (pu && po) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                unf_evt = 1'b1;
            end else begin
                exp_q.push_back(stk[stk.size()-1]);
                stk[stk.size()-1] = d;
                valid = 1'b1;
            end
        end else if (pu) begin
            if (stk.size() == DEPTH) ovf_evt = 1'b1;
            else stk.push_back(d);
        end else if (po) begin
            if (stk.size() == 0) begin
                unf_evt = 1'b1;
            end else begin
                exp_q.push_back(stk.pop_back());
                valid = 1'b1;
            end
        end
        m_ovf = ovf_evt | (m_ovf & ~clr);
        m_unf = unf_evt | (m_unf & ~clr);
        @(posedge Clk);
        #1;
        Push   = 1'b0;
        Pop    = 1'b0;
        ErrClr = 1'b0;
        chk("datavalid", 32'(DataValid), 32'(valid));
        if (valid && exp_q.size() > 0) m_dout = exp_q.pop_front();
        chk("dataout", 32'(DataOut), 32'(m_dout));
        check_state();
    endtask

    task automatic do_reset(input bit pu, input logic [WIDTH-1:0] d);
        Reset  = 1'b1;
        Push   = pu;
        Pop    = 1'b0;
        ErrClr = 1'b0;
        DataIn = d;
        stk.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Push  = 1'b0;
        chk("rst_datavalid", 32'(DataValid), 32'd0);
        chk("rst_dataout",   32'(DataOut),   32'd0);
        check_state();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; Push = 1'b0; Pop = 1'b0; ErrClr = 1'b0; DataIn = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        @(negedge Clk);

        do_reset(1'b0, '0);

        // Fill to full
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
        chk("fill_full",  32'(Full),  32'd1);
        chk("fill_top",   32'(Top),   32'h008);
        chk("fill_count", 32'(Count), 32'd8);

        // Overflow, then clear
        step(1'b1, 1'b0, 1'b0, 12'hABC);
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_top",  32'(Top),      32'h008);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("ovf_clr",  32'(Overflow), 32'd0);

        // Replace while full
        step(1'b1, 1'b1, 1'b0, 12'h5A5);
        chk("repl_full_out", 32'(DataOut), 32'h008);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("pop_repl_val",  32'(DataOut), 32'h5A5);
        step(1'b1, 1'b0, 1'b0, 12'h008);

        // Drain
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
        chk("drain_last", 32'(DataOut), 32'h001);
        chk("drain_empty", 32'(Empty), 32'd1);

        // Idle cycle: DataValid drops, DataOut holds
        step(1'b0, 1'b0, 1'b0, '0);

        // Underflow on empty pop
        step(1'b0, 1'b1, 1'b0, '0);
        chk("unf_flag", 32'(Underflow), 32'd1);
        chk("unf_dout", 32'(DataOut),   32'h001);

        // Clear coinciding with new underflow: error wins
        step(1'b0, 1'b1, 1'b1, '0);
        chk("unf_clr_wins", 32'(Underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0);

        // Replace on empty: acts as push plus underflow
        step(1'b1, 1'b1, 1'b0, 12'h111);
        chk("repl_empty_cnt", 32'(Count),     32'd1);
        chk("repl_empty_unf", 32'(Underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0);

        // Replace on a two-entry stack
        step(1'b1, 1'b0, 1'b0, 12'h222);
        step(1'b1, 1'b1, 1'b0, 12'h333);
        chk("repl_out",   32'(DataOut), 32'h222);
        chk("repl_top",   32'(Top),     32'h333);
        chk("repl_count", 32'(Count),   32'd2);

        // Third entry then reset with Push held
        step(1'b1, 1'b0, 1'b0, 12'h444);
        do_reset(1'b1, 12'h777);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_unf", 32'(Underflow), 32'd1);

        // Refill past the almost-full threshold
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 12'h100 + WIDTH'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
